// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one multi-cycle ALU between two requesters. Requests are granted
// round-robin. Each job runs the ALU through a fixed handshake:
//    IDLE -> CLR -> START -> HOLD -> OPB -> DONE -> IDLE
// The ALU is reset, started with the first operand, and then given the second
// operand until it signals finish. The result is returned to the requester
// that issued the job.
//
// Handshake: a request transfers on the rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is only ever high in IDLE, and only
// for the requester that wins arbitration in that cycle. A requester must hold
// valid and its operands stable until the transfer. rsp_valid[i] is a
// one-cycle pulse with no back-pressure. rsp_result, rsp_of and rsp_timeout
// keep their values until the next completed job.
//
// Optional feature (macro ALU_ARB_TIMEOUT_EN): OPB watchdog. When the macro is
// defined, a job that stays in OPB for TIMEOUT_CYCLES cycles without
// alu_finish is aborted and reported with rsp_timeout=1. When it is undefined,
// OPB waits forever and rsp_timeout is tied low.
//
// Parameters
//    TIMEOUT_CYCLES  maximum number of OPB cycles before abort (watchdog only)
//
// Ports
//    clk          in   1   sole clock, rising edge
//    rst          in   1   synchronous, active-high reset
//    req_valid    in   2   per-requester request valid
//    req_ready    out  2   per-requester accept (IDLE, granted requester only)
//    req_sel      in   4   op code, [2i+1:2i]: 00 add, 01 sub, 10 mul, 11 div
//    req_opa      in   32  first operand, [16i+15:16i]
//    req_opb      in   16  second operand, [8i+7:8i]
//    rsp_valid    out  2   one-cycle completion pulse to the job's requester
//    rsp_result   out  16  result of the last completed job
//    rsp_of       out  1   overflow of the last completed job
//    rsp_timeout  out  1   last job was aborted by the watchdog
//    busy         out  1   high in every state except IDLE
//    alu_rst      out  1   ALU reset (rst OR the CLR state)
//    alu_start    out  1   ALU start
//    alu_sel      out  2   ALU op select
//    alu_inbus    out  16  ALU input bus
//    alu_outbus   in   16  ALU result bus
//    alu_finish   in   1   ALU done (only looked at in OPB)
//    alu_of       in   1   ALU overflow flag
//    o_dbg_state  out  3   current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [3:0]  req_sel,
   input  logic [31:0] req_opa,
   input  logic [15:0] req_opb,
   output logic [1:0]  rsp_valid,
   output logic [15:0] rsp_result,
   output logic        rsp_of,
   output logic        rsp_timeout,
   output logic        busy,
   output logic        alu_rst,
   output logic        alu_start,
   output logic [1:0]  alu_sel,
   output logic [15:0] alu_inbus,
   input  logic [15:0] alu_outbus,
   input  logic        alu_finish,
   input  logic        alu_of,
   output logic [2:0]  o_dbg_state
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("alu_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_START = 3'd2,
      S_HOLD  = 3'd3,
      S_OPB   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      r_state;
   logic        r_last;       // requester granted most recently
   logic        r_gnt;        // requester that owns the current job
   logic [1:0]  r_sel;
   logic [15:0] r_opa;
   logic [7:0]  r_opb;
   logic        r_of_acc;     // alu_of seen so far in HOLD/OPB of this job
   logic [15:0] r_result;
   logic        r_of;
   logic [1:0]  r_rsp_valid;
   logic        r_alu_clr;
   logic        r_alu_start;
   logic [1:0]  r_alu_sel;
   logic [15:0] r_alu_inbus;

   logic [1:0]  w_grant;      // one-hot grant, zero when nobody is asking
   logic        w_gnt_idx;
   logic        w_expired;

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_opb_cnt;  // OPB cycles already spent without finish
   logic          r_timeout;
   assign w_expired   = (r_opb_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign rsp_timeout = r_timeout;
`else
   assign w_expired   = 1'b0;
   assign rsp_timeout = 1'b0;
`endif

   // Round-robin: a lone requester always wins; on a tie the requester that
   // was not granted last time wins.
   always_comb begin
      w_grant = 2'b00;
      case (req_valid)
         2'b01:   w_grant = 2'b01;
         2'b10:   w_grant = 2'b10;
         2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
         default: w_grant = 2'b00;
      endcase
   end
   assign w_gnt_idx = w_grant[1];

   assign req_ready   = (r_state == S_IDLE && !rst) ? w_grant : 2'b00;
   assign busy        = (r_state != S_IDLE);
   assign alu_rst     = rst | r_alu_clr;
   assign alu_start   = r_alu_start;
   assign alu_sel     = r_alu_sel;
   assign alu_inbus   = r_alu_inbus;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_result  = r_result;
   assign rsp_of      = r_of;
   assign o_dbg_state = r_state;

   // ALU-facing outputs are registered: each transition loads the values the
   // ALU must see during the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last      <= 1'b1;
         r_gnt       <= 1'b0;
         r_sel       <= 2'b00;
         r_opa       <= 16'h0000;
         r_opb       <= 8'h00;
         r_of_acc    <= 1'b0;
         r_result    <= 16'h0000;
         r_of        <= 1'b0;
         r_rsp_valid <= 2'b00;
         r_alu_clr   <= 1'b0;
         r_alu_start <= 1'b0;
         r_alu_sel   <= 2'b00;
         r_alu_inbus <= 16'h0000;
`ifdef ALU_ARB_TIMEOUT_EN
         r_opb_cnt   <= '0;
         r_timeout   <= 1'b0;
`endif
      end else begin
         r_rsp_valid <= 2'b00;
         r_alu_clr   <= 1'b0;
         r_alu_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant != 2'b00) begin
                  r_last      <= w_gnt_idx;
                  r_gnt       <= w_gnt_idx;
                  r_sel       <= w_gnt_idx ? req_sel[3:2]    : req_sel[1:0];
                  r_opa       <= w_gnt_idx ? req_opa[31:16]  : req_opa[15:0];
                  r_opb       <= w_gnt_idx ? req_opb[15:8]   : req_opb[7:0];
                  r_of_acc    <= 1'b0;
                  r_alu_clr   <= 1'b1;
                  r_alu_sel   <= 2'b00;
                  r_alu_inbus <= 16'h0000;
                  r_state     <= S_CLR;
               end
            end
            S_CLR: begin
               r_alu_start <= 1'b1;
               r_alu_sel   <= r_sel;
               r_alu_inbus <= r_opa;
               r_state     <= S_START;
            end
            S_START: begin
               r_state <= S_HOLD;
            end
            S_HOLD: begin
               r_of_acc    <= r_of_acc | alu_of;
               r_alu_inbus <= {8'h00, r_opb};
`ifdef ALU_ARB_TIMEOUT_EN
               r_opb_cnt   <= '0;
`endif
               r_state     <= S_OPB;
            end
            S_OPB: begin
               if (alu_finish) begin
                  r_result    <= alu_outbus;
                  // mul/div never report overflow
                  r_of        <= (r_of_acc | alu_of) & ~r_sel[1];
                  r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
                  r_alu_sel   <= 2'b00;
                  r_alu_inbus <= 16'h0000;
`ifdef ALU_ARB_TIMEOUT_EN
                  r_timeout   <= 1'b0;
`endif
                  r_state     <= S_DONE;
               end else if (w_expired) begin
                  r_result    <= 16'h0000;
                  r_of        <= 1'b0;
                  r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
                  r_alu_sel   <= 2'b00;
                  r_alu_inbus <= 16'h0000;
`ifdef ALU_ARB_TIMEOUT_EN
                  r_timeout   <= 1'b1;
`endif
                  r_state     <= S_DONE;
               end else begin
                  r_of_acc  <= r_of_acc | alu_of;
`ifdef ALU_ARB_TIMEOUT_EN
                  r_opb_cnt <= r_opb_cnt + CW'(1);
`endif
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A stub ALU answers each job after a
// chosen delay with a result computed by a reference ALU function. A
// job-level model tracks the accepted job and the cycles since acceptance, and
// derives every DUT output from that: ready from round-robin, ALU bus contents
// from the cycle position in the job, and response contents from the
// reference ALU. Directed cases pin the model to literal values, then a
// randomized phase runs with noise on alu_finish/alu_of outside the OPB window.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_arbiter;

   localparam int TO = 8;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_sel;
   logic [31:0] req_opa;
   logic [15:0] req_opb;
   logic [1:0]  rsp_valid;
   logic [15:0] rsp_result;
   logic        rsp_of;
   logic        rsp_timeout;
   logic        busy;
   logic        alu_rst;
   logic        alu_start;
   logic [1:0]  alu_sel;
   logic [15:0] alu_inbus;
   logic [15:0] alu_outbus;
   logic        alu_finish;
   logic        alu_of;
   logic [2:0]  dbg_state;

   alu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
      .req_opa(req_opa), .req_opb(req_opb),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_of(rsp_of),
      .rsp_timeout(rsp_timeout), .busy(busy),
      .alu_rst(alu_rst), .alu_start(alu_start), .alu_sel(alu_sel),
      .alu_inbus(alu_inbus), .alu_outbus(alu_outbus),
      .alu_finish(alu_finish), .alu_of(alu_of),
      .o_dbg_state(dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference functions ----------------
   // Returns {overflow, result}.
   function automatic logic [16:0] alu_ref(logic [1:0] s, logic [15:0] a, logic [7:0] b);
      logic signed [8:0]  t;
      logic signed [15:0] p;
      logic [15:0]        q;
      logic [15:0]        rm;
      case (s)
         2'b00: begin
            t = $signed({a[7], a[7:0]}) + $signed({b[7], b});
            return {t[8] != t[7], 8'h00, t[7:0]};
         end
         2'b01: begin
            t = $signed({a[7], a[7:0]}) - $signed({b[7], b});
            return {t[8] != t[7], 8'h00, t[7:0]};
         end
         2'b10: begin
            p = $signed({{8{a[7]}}, a[7:0]}) * $signed({{8{b[7]}}, b});
            return {(p > 16'sd127) || (p < -16'sd128), p};
         end
         default: begin
            if (b == 8'h00) return {1'b1, 16'hFFFF};
            q  = a / {8'h00, b};
            rm = a % {8'h00, b};
            return {q > 16'd255, rm[7:0], q[7:0]};
         end
      endcase
   endfunction

   function automatic logic [1:0] grant_of(logic [1:0] v, bit last);
      if (v == 2'b11) return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   // ---------------- model state ----------------
   bit          started  = 0;
   bit          m_busy   = 0;
   bit          m_done   = 0;
   bit          m_last   = 1;
   bit          m_rst_seen = 0;
   bit          m_g      = 0;
   int          lat      = 0;     // cycles since the accept edge
   int          cur_d    = 0;     // extra OPB cycles before the stub finishes
   int          force_d  = -1;
   logic [1:0]  j_sel    = 2'b00;
   logic [15:0] j_opa    = 16'h0;
   logic [7:0]  j_opb    = 8'h0;
   logic [15:0] m_res    = 16'h0;
   bit          m_of     = 0;
   bit          m_to     = 0;
   bit          of_acc   = 0;

   // ---------------- request driver state ----------------
   bit   [1:0]  pend     = 2'b00;
   bit          rand_en  = 0;
   bit          noise_en = 0;
   logic [1:0]  p_sel [2];
   logic [15:0] p_opa [2];
   logic [7:0]  p_opb [2];

   task automatic issue(int i, logic [1:0] s, logic [15:0] a, logic [7:0] b);
      p_sel[i] = s;
      p_opa[i] = a;
      p_opb[i] = b;
      pend[i]  = 1'b1;
   endtask

   // ---------------- model update on the active edge ----------------
   always @(posedge clk) begin : model
      logic [1:0]  gv;
      logic [16:0] rr;
      started    = 1;
      m_rst_seen = rst;
      if (rst) begin
         m_busy = 0; m_done = 0; m_last = 1;
         m_res = 16'h0; m_of = 0; m_to = 0; lat = 0;
      end else if (m_done) begin
         m_done = 0;
         m_busy = 0;
      end else if (!m_busy) begin
         gv = grant_of(req_valid, m_last);
         if (gv != 2'b00) begin
            m_g    = gv[1];
            m_last = gv[1];
            j_sel  = p_sel[m_g];
            j_opa  = p_opa[m_g];
            j_opb  = p_opb[m_g];
            pend[m_g] = 1'b0;
            m_busy = 1;
            lat    = 0;
            of_acc = 0;
            cur_d  = (force_d >= 0) ? force_d : $urandom_range(0, 3);
         end
      end else begin
         if (lat >= 2) of_acc = of_acc | alu_of;
         if (lat >= 3 && alu_finish) begin
            rr     = alu_ref(j_sel, j_opa, j_opb);
            m_done = 1;
            m_res  = rr[15:0];
            m_of   = of_acc & ~j_sel[1];
            m_to   = 0;
         end
`ifdef ALU_ARB_TIMEOUT_EN
         else if (lat >= 3 && (lat - 3) == TO - 1) begin
            m_done = 1;
            m_res  = 16'h0;
            m_of   = 0;
            m_to   = 1;
         end
`endif
         else begin
            lat++;
         end
      end
   end

   // ---------------- compare, stub ALU and request driver ----------------
   always @(negedge clk) begin : cmp_drv
      logic [1:0]  exp_rdy;
      logic [16:0] rr;
      bit          job;
      bit          fin;
      job = m_busy && !m_done;
      if (started) begin
         chk("busy", busy, m_busy);
         exp_rdy = (!m_busy && !rst) ? grant_of(req_valid, m_last) : 2'b00;
         chk("req_ready", req_ready, exp_rdy);
         chk("alu_rst", alu_rst, rst || (job && lat == 0));
         chk("alu_start", alu_start, job && lat == 1);
         if (job) begin
            chk("alu_sel", alu_sel, (lat == 0) ? 2'b00 : j_sel);
            chk("alu_inbus", alu_inbus,
                (lat == 0) ? 16'h0 : ((lat < 3) ? j_opa : {8'h00, j_opb}));
         end
         if (m_rst_seen) begin
            chk("rst_alu_sel", alu_sel, 2'b00);
            chk("rst_alu_inbus", alu_inbus, 16'h0);
         end
         chk("rsp_valid", rsp_valid, m_done ? (m_g ? 2'b10 : 2'b01) : 2'b00);
         chk("rsp_result", rsp_result, m_res);
         chk("rsp_of", rsp_of, m_of);
         chk("rsp_timeout", rsp_timeout, m_to);
      end

      // stub ALU: finishes cur_d cycles into OPB, noise elsewhere
      fin = job && lat >= 3 && (lat - 3) == cur_d;
      rr  = alu_ref(j_sel, j_opa, j_opb);
      if (fin) begin
         alu_finish = 1'b1;
         alu_outbus = rr[15:0];
         alu_of     = rr[16] | (noise_en && $urandom_range(0, 3) == 0);
      end else begin
         alu_finish = noise_en && !(job && lat >= 3) && ($urandom_range(0, 1) == 1);
         alu_outbus = 16'($urandom);
         alu_of     = noise_en && ($urandom_range(0, 5) == 0);
      end

      // requesters: idle ones scramble their operand lines, busy ones hold
      for (int i = 0; i < 2; i++) begin
         if (!pend[i]) begin
            p_sel[i] = 2'($urandom);
            p_opa[i] = 16'($urandom);
            p_opb[i] = 8'($urandom);
            if (rand_en && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
         end
      end
      req_valid = pend;
      req_sel   = {p_sel[1], p_sel[0]};
      req_opa   = {p_opa[1], p_opa[0]};
      req_opb   = {p_opb[1], p_opb[0]};
   end

   // ---------------- directed driver tasks ----------------
   task automatic wait_rsp(output logic [1:0] v, output logic [15:0] r,
                           output logic o, output logic t, output int n);
      n = 0;
      v = 2'b00;
      while (v == 2'b00 && n < 300) begin
         @(negedge clk); #1;
         n++;
         v = rsp_valid;
      end
      r = rsp_result;
      o = rsp_of;
      t = rsp_timeout;
      if (v == 2'b00) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_rsp: no rsp_valid within %0d cycles", n);
      end
      @(posedge clk); #2;
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic [1:0]  v;
      logic [15:0] r;
      logic        o;
      logic        t;
      int          n;
      rst        = 1'b1;
      req_valid  = 2'b00;
      req_sel    = 4'h0;
      req_opa    = 32'h0;
      req_opb    = 16'h0;
      alu_finish = 1'b0;
      alu_of     = 1'b0;
      alu_outbus = 16'h0;
      for (int i = 0; i < 2; i++) begin
         p_sel[i] = 2'b00; p_opa[i] = 16'h0; p_opb[i] = 8'h0;
      end

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 1'b0);
      chk("reset_rsp_valid", rsp_valid, 2'b00);
      chk("reset_rsp_result", rsp_result, 16'h0);
      chk("reset_alu_rst", alu_rst, 1'b1);
      chk("reset_req_ready", req_ready, 2'b00);
      chk("reset_alu_start", alu_start, 1'b0);
      #1;

      // both requesters valid on the first cycle after reset
      force_d = 1;
      issue(0, 2'b10, 16'hFFE7, 8'hD6);   // -25 * -42
      issue(1, 2'b01, 16'd178, 8'd34);    // 178 - 34
      rst = 1'b0;
      wait_rsp(v, r, o, t, n);
      chk("tie_first_grant", v, 2'b01);
      chk("mul_result", r, 16'd1050);
      chk("mul_of_masked", o, 1'b0);
      wait_rsp(v, r, o, t, n);
      chk("tie_second_grant", v, 2'b10);
      chk("sub_result", r[7:0], 8'd144);

      // single add, minimum latency
      force_d = 0;
      issue(0, 2'b00, 16'd20, 8'd75);
      wait_rsp(v, r, o, t, n);
      chk("add_rsp_valid", v, 2'b01);
      chk("add_result", r[7:0], 8'd95);
      chk("add_of", o, 1'b0);
      chk("add_latency", n, 6);

      // add with signed overflow from requester 1
      issue(1, 2'b00, 16'd127, 8'd126);
      wait_rsp(v, r, o, t, n);
      chk("ovf_rsp_valid", v, 2'b10);
      chk("ovf_result", r[7:0], 8'hFD);
      chk("ovf_of", o, 1'b1);

      // reset pulsed during OPB aborts the job and restores last_grant
      force_d = 100000;
      issue(0, 2'b00, 16'd1, 8'd2);
      for (int k = 0; k < 50 && !(m_busy && lat >= 4); k++) begin
         @(posedge clk); #2;
      end
      chk("reached_opb", m_busy && lat >= 4, 1'b1);
      rst = 1'b1;
      #1;
      chk("abort_alu_rst", alu_rst, 1'b1);
      @(posedge clk); #2;
      chk("abort_busy", busy, 1'b0);
      rst     = 1'b0;
      force_d = 0;
      issue(0, 2'b00, 16'd3, 8'd4);
      issue(1, 2'b00, 16'd5, 8'd6);
      wait_rsp(v, r, o, t, n);
      chk("post_abort_grant", v, 2'b01);
      chk("post_abort_result", r[7:0], 8'd7);
      wait_rsp(v, r, o, t, n);
      chk("post_abort_second", v, 2'b10);

`ifdef ALU_ARB_TIMEOUT_EN
      // watchdog: ALU never finishes
      force_d = 100000;
      issue(1, 2'b00, 16'd5, 8'd6);
      wait_rsp(v, r, o, t, n);
      chk("timeout_flag", t, 1'b1);
      chk("timeout_result", r, 16'h0);
      chk("timeout_latency", n, 5 + TO);
      force_d = 0;
      issue(1, 2'b00, 16'd1, 8'd1);
      wait_rsp(v, r, o, t, n);
      chk("timeout_cleared", t, 1'b0);
      chk("after_timeout_result", r[7:0], 8'd2);
`endif

      // randomized traffic with ALU noise
      force_d  = -1;
      noise_en = 1;
      rand_en  = 1;
      repeat (4000) @(posedge clk);
      #2;
      rand_en = 0;
      for (int k = 0; k < 200 && (pend != 2'b00 || m_busy); k++) begin
         @(posedge clk); #2;
      end
      chk("drain", {30'h0, pend} | {31'h0, m_busy}, 32'h0);
      noise_en = 0;
      repeat (3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
